// File: rtl/dsi_pixel_feeder.sv
// -----------------------------------------------------------------------------
// dsi_pixel_feeder
//
// Upstream stage of the DSI pixel serializer. Buffers 24-bit RGB pixels from a
// valid/ready source in a small circular FIFO. It presents one stable word per
// serializer slot: SLOT cycles, made of one load cycle followed by 24 shift
// cycles. When the source falls behind, it substitutes BLANK words.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 4)
//   PREFILL      FIFO level required before leaving IDLE (1..DEPTH)
//   SLOT         cycles per output word (serializer load+shift period)
//   LINE_PIXELS  real pixels per line (1..65535)
//   BLANK        word presented while idle or starved
//
// Ports
//   clk, rst        single rising-edge clock, asynchronous active-high reset
//   in_pixel        source pixel {R,G,B}
//   in_valid        in_pixel valid
//   in_ready        FIFO not full (decoded from the registered level)
//   pixel_data      word for the serializer; changes only on slot boundaries
//   load_strobe     high for the first cycle of each slot
//   line_done       pulse with load_strobe when the word ends a line
//   underflow       pulse with load_strobe when BLANK is forced while running
//   fifo_level      current FIFO occupancy
//   underflow_count saturating count of underflow pulses. This port exists
//                   only when FEEDER_UNDERFLOW_CNT_EN is defined.
//
// Build option: define FEEDER_UNDERFLOW_CNT_EN to add underflow_count.
// -----------------------------------------------------------------------------
module dsi_pixel_feeder #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned PREFILL     = 4,
  parameter int unsigned SLOT        = 25,
  parameter int unsigned LINE_PIXELS = 640,
  parameter logic [23:0] BLANK       = 24'h000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [23:0]              in_pixel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [23:0]              pixel_data,
  output logic                     load_strobe,
  output logic                     line_done,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef FEEDER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]              underflow_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = (SLOT > 1) ? $clog2(SLOT) : 1;

  localparam logic [LW-1:0] FULL_LVL    = LW'(DEPTH);
  localparam logic [LW-1:0] PREFILL_LVL = LW'(PREFILL);
  localparam logic [SW-1:0] SLOT_LAST   = SW'(SLOT - 1);
  localparam logic [15:0]   LINE_LAST   = 16'(LINE_PIXELS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [23:0]    mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic [SW-1:0]  slot_cnt;
  logic [0:0]     state;
  logic [15:0]    line_cnt;

  logic boundary;
  logic push;
  logic pop;
  logic starve;
  logic level_ok;
  logic line_end;

  // Every decision below uses the registered level from before the edge.
  // A push on a boundary edge therefore only becomes visible in the next slot.
  assign boundary   = (slot_cnt == SLOT_LAST);
  assign in_ready   = (level != FULL_LVL);
  assign push       = in_valid && in_ready;
  assign level_ok   = (state == ST_RUN) ? (level != '0) : (level >= PREFILL_LVL);
  assign pop        = boundary && level_ok;
  assign starve     = boundary && (state == ST_RUN) && (level == '0);
  assign line_end   = (line_cnt == LINE_LAST);
  assign fifo_level = level;

  // FIFO storage is pure data; its stale contents are unreachable after reset
  // because the pointers and the level are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_pixel;
    end
  end

  // FIFO pointers and level. DEPTH is a power of two, so the pointers wrap
  // naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Slot timing. The counter free-runs in both states, so slot phase depends
  // only on the time since reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt    <= '0;
      load_strobe <= 1'b0;
    end else begin
      slot_cnt    <= boundary ? '0 : slot_cnt + 1'b1;
      load_strobe <= boundary;
    end
  end

  // Output word and state machine. Words are loaded only on boundary edges.
  // An empty FIFO in RUN yields one underflow pulse and a return to IDLE,
  // where PREFILL entries must build up again before streaming resumes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pixel_data <= BLANK;
      underflow  <= 1'b0;
    end else begin
      underflow <= starve;
      if (boundary) begin
        if (pop) begin
          pixel_data <= mem[rd_ptr];
          state      <= ST_RUN;
        end else begin
          pixel_data <= BLANK;
          state      <= ST_IDLE;
        end
      end
    end
  end

  // Line position. Only popped pixels count, so BLANK slots never move the
  // line boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_cnt  <= '0;
      line_done <= 1'b0;
    end else begin
      line_done <= pop && line_end;
      if (pop) begin
        line_cnt <= line_end ? '0 : line_cnt + 1'b1;
      end
    end
  end

`ifdef FEEDER_UNDERFLOW_CNT_EN
  // The count advances on the same edge that raises underflow, so both are
  // visible in the same cycle. It holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_count <= '0;
    end else if (starve && (underflow_count != 16'hFFFF)) begin
      underflow_count <= underflow_count + 1'b1;
    end
  end
`endif

endmodule
